mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_ctrl_pkg.sv | 45 ++++
 rtl/mc_wait_timer.sv | 41 ++++
 rtl/mc_control_fsm.sv | 184 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM: state codes,
// pc_sel codes, wait-timer width and the default memory timeout.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    localparam int TIMEOUT_CYCLES_DEFAULT = 15;
    localparam int WAIT_CNT_W             = 8;

    // Decoder flags captured at the end of DECODE.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic branch;
        logic jump;
    } dec_flags_t;

    // Jump has priority over a taken branch; otherwise sequential.
    function automatic logic [1:0] pc_sel_f(
        input dec_flags_t f,
        input logic       taken
    );
        if (f.jump) begin
            return PC_SEL_JUMP;
        end else if (f.branch && taken) begin
            return PC_SEL_BRANCH;
        end
        return PC_SEL_SEQ;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait timer: counts stalled cycles, flags expiry on the last
// allowed stall cycle. Ports: clk, resetn, clear, count -> expire.
module mc_wait_timer
    import mc_ctrl_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam logic [WAIT_CNT_W-1:0] LAST = WAIT_CNT_W'(LIMIT - 1);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    // Expiry depends only on the stored count, never on clear, so the
    // FSM can use it to pick its next state without a loop.
    assign expire = count && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control FSM: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives imem/dmem/rf/pc strobes, counts retired instructions and
// latches a sticky fault when a memory stalls past TIMEOUT_CYCLES.
// Ports: clk, resetn, halt; imem_req/imem_ready, ir_we; dec_* flags,
// br_taken; dmem_req/dmem_we/dmem_ready; rf_we, wb_sel; pc_we, pc_sel;
// state, timeout_err, instret.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        halt,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        ir_we,
    input  logic        dec_reg_write,
    input  logic        dec_mem_to_reg,
    input  logic        dec_mem_write,
    input  logic        dec_branch,
    input  logic        dec_jump,
    input  logic        br_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  state,
    output logic        timeout_err,
    output logic [31:0] instret
);

    state_e      state_q;
    state_e      state_d;
    dec_flags_t  flags_q;
    dec_flags_t  flags_d;
    logic        taken_q;
    logic        taken_d;
    logic [31:0] instret_q;
    logic [31:0] instret_d;
    logic        timeout_err_q;
    logic        timeout_err_d;

    logic        wait_count;
    logic        wait_clear;
    logic        wait_expire;
    logic        complete;

    // Stall cycles are those spent in FETCH/MEM without a ready.
    assign wait_count = ((state_q == ST_FETCH) && !imem_ready) ||
                        ((state_q == ST_MEM)   && !dmem_ready);

    // Any state change restarts the count, so FETCH and MEM are always
    // entered with a cleared timer.
    assign wait_clear = (state_d != state_q);

    mc_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (wait_clear),
        .count  (wait_count),
        .expire (wait_expire)
    );

    always_comb begin
        state_d       = state_q;
        flags_d       = flags_q;
        taken_d       = taken_q;
        instret_d     = instret_q;
        timeout_err_d = timeout_err_q;
        complete      = 1'b0;
        imem_req      = 1'b0;
        ir_we         = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        rf_we         = 1'b0;
        wb_sel        = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = PC_SEL_SEQ;

        unique case (state_q)
            ST_IDLE: begin
                state_d = halt ? ST_HALT : ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_DECODE: begin
                flags_d.reg_write  = dec_reg_write;
                flags_d.mem_to_reg = dec_mem_to_reg;
                flags_d.mem_write  = dec_mem_write;
                flags_d.branch     = dec_branch;
                flags_d.jump       = dec_jump;
                taken_d            = 1'b0;
                state_d            = ST_EXEC;
            end
            ST_EXEC: begin
                // Keep the branch outcome for completion in MEM/WB.
                taken_d = br_taken;
                if (flags_q.mem_write || flags_q.mem_to_reg) begin
                    state_d = ST_MEM;
                end else if (flags_q.reg_write) begin
                    state_d = ST_WB;
                end else begin
                    complete = 1'b1;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = flags_q.mem_write;
                if (dmem_ready) begin
                    if (flags_q.mem_to_reg) begin
                        state_d = ST_WB;
                    end else begin
                        complete = 1'b1;
                    end
                end else if (wait_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB: begin
                rf_we    = 1'b1;
                wb_sel   = flags_q.mem_to_reg;
                complete = 1'b1;
            end
            ST_HALT: begin
                if (!halt) begin
                    state_d = ST_FETCH;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        // Single retirement point shared by EXEC, MEM and WB.
        if (complete) begin
            pc_we     = 1'b1;
            pc_sel    = pc_sel_f(flags_q,
                                 (state_q == ST_EXEC) ? br_taken : taken_q);
            instret_d = instret_q + 32'd1;
            state_d   = halt ? ST_HALT : ST_FETCH;
        end

        if (state_d == ST_ERR) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            flags_q       <= '0;
            taken_q       <= 1'b0;
            instret_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flags_q       <= flags_d;
            taken_q       <= taken_d;
            instret_q     <= instret_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign state       = state_q;
    assign timeout_err = timeout_err_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: a per-instruction plan of
// cycles (inputs + expected outputs) is built from the sequencing rules.
module tb_mc_control_fsm;

    localparam int TO = 15;

    localparam int B_IMEM = 6;
    localparam int B_IR   = 5;
    localparam int B_DREQ = 4;
    localparam int B_DWE  = 3;
    localparam int B_RF   = 2;
    localparam int B_PC   = 1;
    localparam int B_WB   = 0;

    logic        clk;
    logic        resetn;
    logic        halt;
    logic        imem_req;
    logic        imem_ready;
    logic        ir_we;
    logic        dec_reg_write;
    logic        dec_mem_to_reg;
    logic        dec_mem_write;
    logic        dec_branch;
    logic        dec_jump;
    logic        br_taken;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        rf_we;
    logic        wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic        timeout_err;
    logic [31:0] instret;

    mc_control_fsm #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .halt           (halt),
        .imem_req       (imem_req),
        .imem_ready     (imem_ready),
        .ir_we          (ir_we),
        .dec_reg_write  (dec_reg_write),
        .dec_mem_to_reg (dec_mem_to_reg),
        .dec_mem_write  (dec_mem_write),
        .dec_branch     (dec_branch),
        .dec_jump       (dec_jump),
        .br_taken       (br_taken),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_ready     (dmem_ready),
        .rf_we          (rf_we),
        .wb_sel         (wb_sel),
        .pc_we          (pc_we),
        .pc_sel         (pc_sel),
        .state          (state),
        .timeout_err    (timeout_err),
        .instret        (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // fl = {reg_write, mem_to_reg, mem_write, branch, jump}
    typedef struct {
        logic        rst_n;
        logic        chk;
        logic        halt;
        logic        imem_rdy;
        logic        dmem_rdy;
        logic        bt;
        logic [4:0]  fl;
        logic [2:0]  st;
        logic [6:0]  strb;
        logic [1:0]  psel;
        logic [31:0] iret;
        logic        terr;
    } cyc_t;

    cyc_t        plan[$];
    int unsigned cnt;
    int          n_chk;
    int          n_fail;
    int          cyc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    // Unconstrained inputs are randomised; expectations default to idle.
    function automatic cyc_t rnd_cyc(input logic [2:0] st);
        cyc_t c;
        c.rst_n    = 1'b1;
        c.chk      = 1'b1;
        c.halt     = 1'($urandom);
        c.imem_rdy = 1'($urandom);
        c.dmem_rdy = 1'($urandom);
        c.bt       = 1'($urandom);
        c.fl       = 5'($urandom);
        c.st       = st;
        c.strb     = '0;
        c.psel     = 2'b00;
        c.iret     = cnt;
        c.terr     = 1'b0;
        return c;
    endfunction

    task automatic push_reset(input logic [2:0] st);
        cyc_t c;
        c       = rnd_cyc(st);
        c.rst_n = 1'b0;
        c.chk   = 1'b0;
        plan.push_back(c);
        cnt     = 0;
        c       = rnd_cyc(0);
        c.halt  = 1'b0;
        plan.push_back(c);
    endtask

    task automatic add_err();
        cyc_t c;
        for (int k = 0; k < 3; k++) begin
            c      = rnd_cyc(7);
            c.terr = 1'b1;
            plan.push_back(c);
        end
        push_reset(7);
    endtask

    task automatic finish_instr(input cyc_t c0, input logic [1:0] ps,
                                input int nh);
        cyc_t c;
        c            = c0;
        c.strb[B_PC] = 1'b1;
        c.psel       = ps;
        c.halt       = (nh > 0);
        plan.push_back(c);
        cnt++;
        for (int k = 0; k < nh; k++) begin
            c      = rnd_cyc(6);
            c.halt = (k < nh - 1);
            plan.push_back(c);
        end
    endtask

    function automatic cyc_t mem_cyc(input logic [4:0] fl,
                                     input logic rdy);
        cyc_t c;
        c              = rnd_cyc(4);
        c.dmem_rdy     = rdy;
        c.strb[B_DREQ] = 1'b1;
        c.strb[B_DWE]  = fl[2];
        return c;
    endfunction

    // wi/wd: stall cycles before ready; >= TO means never ready.
    // abort > 0: reset after that many MEM stall cycles.
    task automatic add_instr(input logic [4:0] fl, input int wi,
                             input int wd, input logic bt,
                             input int nh, input int abort);
        cyc_t       c;
        logic [1:0] ps;
        logic       mem;
        mem = fl[3] | fl[2];
        ps  = fl[0] ? 2'b10 : ((fl[1] && bt) ? 2'b01 : 2'b00);
        if (wi >= TO) begin
            for (int k = 0; k < TO; k++) begin
                c              = rnd_cyc(1);
                c.imem_rdy     = 1'b0;
                c.strb[B_IMEM] = 1'b1;
                plan.push_back(c);
            end
            add_err();
            return;
        end
        for (int k = 0; k <= wi; k++) begin
            c              = rnd_cyc(1);
            c.imem_rdy     = (k == wi);
            c.strb[B_IMEM] = 1'b1;
            c.strb[B_IR]   = (k == wi);
            plan.push_back(c);
        end
        c    = rnd_cyc(2);
        c.fl = fl;
        plan.push_back(c);
        c    = rnd_cyc(3);
        c.bt = bt;
        if (!mem && !fl[4]) begin
            finish_instr(c, ps, nh);
            return;
        end
        plan.push_back(c);
        if (mem) begin
            if (abort > 0) begin
                for (int k = 0; k < abort; k++) begin
                    plan.push_back(mem_cyc(fl, 1'b0));
                end
                push_reset(4);
                return;
            end
            if (wd >= TO) begin
                for (int k = 0; k < TO; k++) begin
                    plan.push_back(mem_cyc(fl, 1'b0));
                end
                add_err();
                return;
            end
            for (int k = 0; k <= wd; k++) begin
                c = mem_cyc(fl, k == wd);
                if (k == wd && !fl[3]) begin
                    finish_instr(c, ps, nh);
                    return;
                end
                plan.push_back(c);
            end
        end
        c            = rnd_cyc(5);
        c.strb[B_RF] = 1'b1;
        c.strb[B_WB] = fl[3];
        finish_instr(c, ps, nh);
    endtask

    task automatic add_random(input int n);
        for (int i = 0; i < n; i++) begin
            logic [4:0] fl;
            int         cls;
            int         wi;
            int         wd;
            int         nh;
            cls = int'($urandom_range(0, 6));
            unique case (cls)
                0: fl = 5'b10000;
                1: fl = 5'b11000;
                2: fl = 5'b00100;
                3: fl = 5'b00010;
                4: fl = 5'b10001;
                5: fl = 5'b00001;
                default: fl = 5'($urandom);
            endcase
            wi = ($urandom_range(0, 9) == 0) ? 14
                 : int'($urandom_range(0, 3));
            wd = ($urandom_range(0, 9) == 0) ? 14
                 : int'($urandom_range(0, 3));
            nh = ($urandom_range(0, 4) == 0)
                 ? int'($urandom_range(1, 3)) : 0;
            add_instr(fl, wi, wd, 1'($urandom), nh, 0);
        end
    endtask

    initial begin
        cyc_t c;
        n_chk          = 0;
        n_fail         = 0;
        cyc            = 0;
        cnt            = 0;
        resetn         = 1'b0;
        halt           = 1'b0;
        imem_ready     = 1'b0;
        dmem_ready     = 1'b0;
        br_taken       = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_mem_write  = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;

        // Power-on reset, then IDLE with halt -> HALT -> FETCH.
        c       = rnd_cyc(0);
        c.rst_n = 1'b0;
        c.chk   = 1'b0;
        plan.push_back(c);
        plan.push_back(c);
        c      = rnd_cyc(0);
        c.halt = 1'b1;
        plan.push_back(c);
        c      = rnd_cyc(6);
        c.halt = 1'b0;
        plan.push_back(c);
        // Load abandoned by reset while stalled in MEM.
        add_instr(5'b11000, 0, 0, 1'b0, 0, 2);
        // addi x1,x0,5 (0x00500093): ALU op with writeback.
        add_instr(5'b10000, 0, 0, 1'b0, 0, 0);
        // Load with three dmem stall cycles.
        add_instr(5'b11000, 0, 3, 1'b0, 0, 0);
        // Branch taken, then not taken.
        add_instr(5'b00010, 0, 0, 1'b1, 0, 0);
        add_instr(5'b00010, 0, 0, 1'b0, 0, 0);
        // Store with halt at completion, two HALT cycles.
        add_instr(5'b00100, 0, 3, 1'b0, 2, 0);
        // imem ready on the last allowed cycle: no fault.
        add_instr(5'b10000, 14, 0, 1'b0, 0, 0);
        // Jump-and-link through WB.
        add_instr(5'b10001, 1, 0, 1'b1, 0, 0);
        add_random(60);
        // Fetch timeout, reset, recovery.
        add_instr(5'b10000, TO, 0, 1'b0, 0, 0);
        add_random(4);
        // Data timeout on a load, reset, recovery.
        add_instr(5'b11000, 0, TO, 1'b0, 0, 0);
        add_random(4);

        foreach (plan[i]) begin
            @(posedge clk);
            #1;
            c              = plan[i];
            resetn         = c.rst_n;
            halt           = c.halt;
            imem_ready     = c.imem_rdy;
            dmem_ready     = c.dmem_rdy;
            br_taken       = c.bt;
            dec_reg_write  = c.fl[4];
            dec_mem_to_reg = c.fl[3];
            dec_mem_write  = c.fl[2];
            dec_branch     = c.fl[1];
            dec_jump       = c.fl[0];
            @(negedge clk);
            cyc = i;
            if (c.chk) begin
                check("state", 32'(state), 32'(c.st));
                check("strobes",
                      32'({imem_req, ir_we, dmem_req, dmem_we,
                           rf_we, pc_we, wb_sel}),
                      32'(c.strb));
                check("pc_sel", 32'(pc_sel), 32'(c.psel));
                check("instret", instret, c.iret);
                check("timeout_err", 32'(timeout_err), 32'(c.terr));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
